// File: rtl/sm3_msg_packer.sv
// sm3_msg_packer: byte-stream front end for SM3_top.
// Packs bytes big-endian into words, inserts block gaps, gates SM3_en.
module sm3_msg_packer #(
    parameter int unsigned BLOCK_GAP = 72
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid_in,
    input  logic        byte_last_in,
    output logic        byte_ready_out,
    input  logic        sm3_finished_in,
    output logic        sm3_en_out,
    output logic [31:0] msg_out,
    output logic        msg_valid_out,
    output logic        is_last_word_out,
    output logic [1:0]  last_word_byte_out
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        PACK,
        GAP,
        WAIT_DONE
    } state_t;

    localparam logic [7:0] GAP_LOAD = 8'(BLOCK_GAP);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  lane;
    logic [3:0]  wcnt;
    logic [7:0]  gap_cnt;
    logic [31:0] word_buf;
    logic [31:0] word_nxt;
    logic        accept;
    logic        emit;
    logic        last_acc;
    logic        sm3_en_nxt;
    logic        load_gap;
    logic        clr_ctx;

    // Bytes are only taken while packing; ready never depends on inputs.
    assign byte_ready_out = (state == PACK);
    assign accept         = byte_valid_in && byte_ready_out;
    assign last_acc       = accept && byte_last_in;
    assign emit           = accept && (byte_last_in || (lane == 2'd3));

    // Merge the incoming byte into its big-endian lane of the partial word.
    always_comb begin
        word_nxt = word_buf;
        unique case (lane)
            2'd0: word_nxt[31:24] = byte_in;
            2'd1: word_nxt[23:16] = byte_in;
            2'd2: word_nxt[15:8]  = byte_in;
            2'd3: word_nxt[7:0]   = byte_in;
            default: word_nxt = word_buf;
        endcase
    end

    // Next-state and control strobes.
    always_comb begin
        state_nxt  = state;
        sm3_en_nxt = sm3_en_out;
        load_gap   = 1'b0;
        clr_ctx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (byte_valid_in) begin
                    state_nxt  = ARM;
                    sm3_en_nxt = 1'b1;
                end
            end
            ARM: begin
                state_nxt = PACK;
            end
            PACK: begin
                if (last_acc) begin
                    state_nxt = WAIT_DONE;
                end else if (emit && (wcnt == 4'd15)) begin
                    state_nxt = GAP;
                    load_gap  = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt <= 8'd1) begin
                    state_nxt = PACK;
                end
            end
            WAIT_DONE: begin
                if (sm3_finished_in) begin
                    state_nxt  = IDLE;
                    sm3_en_nxt = 1'b0;
                    clr_ctx    = 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                sm3_en_nxt = 1'b0;
            end
        endcase
    end

    // State register and core enable.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state      <= IDLE;
            sm3_en_out <= 1'b0;
        end else begin
            state      <= state_nxt;
            sm3_en_out <= sm3_en_nxt;
        end
    end

    // Lane counter and partial word; cleared once a word goes out.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in || clr_ctx) begin
            lane     <= 2'd0;
            word_buf <= 32'd0;
        end else if (accept) begin
            if (emit) begin
                lane     <= 2'd0;
                word_buf <= 32'd0;
            end else begin
                lane     <= lane + 2'd1;
                word_buf <= word_nxt;
            end
        end
    end

    // Word position within the 16-word block; wraps naturally.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in || clr_ctx) begin
            wcnt <= 4'd0;
        end else if (emit) begin
            wcnt <= wcnt + 4'd1;
        end
    end

    // Compression gap countdown.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            gap_cnt <= 8'd0;
        end else if (load_gap) begin
            gap_cnt <= GAP_LOAD;
        end else if ((state == GAP) && (gap_cnt != 8'd0)) begin
            gap_cnt <= gap_cnt - 8'd1;
        end
    end

    // Registered word interface toward SM3_top.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            msg_out            <= 32'd0;
            msg_valid_out      <= 1'b0;
            is_last_word_out   <= 1'b0;
            last_word_byte_out <= 2'd0;
        end else begin
            msg_valid_out      <= emit;
            is_last_word_out   <= last_acc;
            last_word_byte_out <= last_acc ? lane : 2'd0;
            if (emit) begin
                msg_out <= word_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sm3_msg_packer.sv
// tb_sm3_msg_packer: directed bench with a byte-list reference model.
// Expected words come from grouping accepted bytes in fours.
module tb_sm3_msg_packer;

    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        byte_last_in;
    logic        byte_ready_out;
    logic        sm3_finished_in;
    logic        sm3_en_out;
    logic [31:0] msg_out;
    logic        msg_valid_out;
    logic        is_last_word_out;
    logic [1:0]  last_word_byte_out;

    always #5 clk_in = ~clk_in;

    sm3_msg_packer #(.BLOCK_GAP(72)) dut (
        .clk_in             (clk_in),
        .reset_n_in         (reset_n_in),
        .byte_in            (byte_in),
        .byte_valid_in      (byte_valid_in),
        .byte_last_in       (byte_last_in),
        .byte_ready_out     (byte_ready_out),
        .sm3_finished_in    (sm3_finished_in),
        .sm3_en_out         (sm3_en_out),
        .msg_out            (msg_out),
        .msg_valid_out      (msg_valid_out),
        .is_last_word_out   (is_last_word_out),
        .last_word_byte_out (last_word_byte_out)
    );

    typedef struct {
        logic [31:0] w;
        logic        last;
        logic [1:0]  lwb;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    logic [7:0]  part_q[$];
    logic [7:0]  tx[$];
    int          waits[128];
    int          cyc = 0;
    int          pulses = 0;
    logic [31:0] last_w;
    logic        last_l;
    logic [1:0]  last_b;
    logic        en_prev = 1'b0;
    int          en_rise_cyc = 0;
    int          first_gap = -1;
    logic        first_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: every 4 accepted bytes (or the last) make one word.
    function automatic void model_accept(input logic [7:0] b,
                                         input logic last);
        exp_t e;
        part_q.push_back(b);
        if (part_q.size() == 4 || last) begin
            e.w = 32'd0;
            foreach (part_q[i]) e.w |= 32'(part_q[i]) << (24 - 8 * i);
            e.last = last;
            e.lwb  = last ? 2'(part_q.size() - 1) : 2'd0;
            exp_q.push_back(e);
            part_q.delete();
        end
    endfunction

    // Compare the word interface against the model every cycle.
    always @(negedge clk_in) begin
        exp_t e;
        cyc++;
        if (sm3_en_out && !en_prev) begin
            en_rise_cyc = cyc;
            first_pend  = 1'b1;
        end
        en_prev = sm3_en_out;
        if (msg_valid_out) begin
            pulses++;
            last_w = msg_out;
            last_l = is_last_word_out;
            last_b = last_word_byte_out;
            if (first_pend) begin
                first_gap  = cyc - en_rise_cyc;
                first_pend = 1'b0;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("msg_out", msg_out, e.w);
                check("is_last", is_last_word_out, e.last);
                check("lwb", last_word_byte_out, e.lwb);
            end
        end else begin
            check("idle_last", is_last_word_out, 0);
            check("idle_lwb", last_word_byte_out, 0);
        end
    end

    task automatic send_msg(input int n, input bit do_last,
                            input int stall_at, input int stall_len,
                            input bit spurious);
        int i = 0;
        int guard;
        for (int k = 0; k < 128; k++) waits[k] = 0;
        while (i < n) begin
            @(negedge clk_in);
            if (i == stall_at) begin
                byte_valid_in   = 1'b0;
                sm3_finished_in = spurious;
                repeat (stall_len) @(negedge clk_in);
                sm3_finished_in = 1'b0;
                stall_at = -1;
            end
            byte_in       = tx[i];
            byte_valid_in = 1'b1;
            byte_last_in  = do_last && (i == n - 1);
            if (byte_ready_out) begin
                model_accept(tx[i], byte_last_in);
                i++;
                guard = 0;
            end else begin
                waits[i]++;
                guard++;
                if (guard > 500) begin
                    check("accept_timeout", 1, 0);
                    byte_valid_in = 1'b0;
                    byte_last_in  = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk_in);
        byte_valid_in = 1'b0;
        byte_last_in  = 1'b0;
    endtask

    // Hold bytes off during WAIT_DONE, then release with a finished pulse.
    task automatic finish_msg();
        byte_in       = 8'hAA;
        byte_valid_in = 1'b1;
        repeat (5) begin
            @(negedge clk_in);
            check("wait_ready", byte_ready_out, 0);
            check("wait_en", sm3_en_out, 1);
        end
        byte_valid_in   = 1'b0;
        @(negedge clk_in);
        sm3_finished_in = 1'b1;
        @(negedge clk_in);
        sm3_finished_in = 1'b0;
        check("en_fall", sm3_en_out, 0);
        @(negedge clk_in);
        check("idle_ready", byte_ready_out, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        check("rst_ready", byte_ready_out, 0);
        check("rst_en", sm3_en_out, 0);
        check("rst_msg", msg_out, 0);
        check("rst_valid", msg_valid_out, 0);
        check("rst_last", is_last_word_out, 0);
        check("rst_lwb", last_word_byte_out, 0);
        reset_n_in = 1'b1;
        part_q.delete();
        exp_q.delete();
    endtask

    task automatic load_abcd(input int n);
        tx.delete();
        for (int k = 0; k < n; k++) tx.push_back(8'h61 + 8'(k % 4));
    endtask

    initial begin
        int p0;
        int s;
        reset_n_in      = 1'b0;
        byte_in         = 8'h00;
        byte_valid_in   = 1'b0;
        byte_last_in    = 1'b0;
        sm3_finished_in = 1'b0;
        do_reset();

        load_abcd(3);
        p0 = pulses;
        send_msg(3, 1'b1, -1, 0, 1'b0);
        @(negedge clk_in);
        check("abc_pulses", pulses - p0, 1);
        check("abc_word", last_w, 32'h61626300);
        check("abc_last", last_l, 1);
        check("abc_lwb", last_b, 2'b10);
        finish_msg();

        load_abcd(64);
        p0 = pulses;
        first_gap = -1;
        send_msg(64, 1'b1, -1, 0, 1'b0);
        @(negedge clk_in);
        s = 0;
        for (int k = 1; k < 64; k++) s += waits[k];
        check("b64_pulses", pulses - p0, 16);
        check("b64_word", last_w, 32'h61626364);
        check("b64_last", last_l, 1);
        check("b64_lwb", last_b, 2'b11);
        check("b64_nogap", s, 0);
        check("b64_arm_wait", waits[0], 2);
        check("b64_en_lead", first_gap >= 2, 1);
        finish_msg();

        load_abcd(64);
        tx.push_back(8'h61);
        p0 = pulses;
        send_msg(65, 1'b1, -1, 0, 1'b0);
        @(negedge clk_in);
        check("b65_pulses", pulses - p0, 17);
        check("b65_gap", waits[64], 72);
        check("b65_word", last_w, 32'h61000000);
        check("b65_last", last_l, 1);
        check("b65_lwb", last_b, 2'b00);
        finish_msg();

        load_abcd(4);
        p0 = pulses;
        send_msg(4, 1'b1, 2, 10, 1'b1);
        @(negedge clk_in);
        check("stall_pulses", pulses - p0, 1);
        check("stall_word", last_w, 32'h61626364);
        check("stall_lwb", last_b, 2'b11);
        check("stall_en", sm3_en_out, 1);
        finish_msg();

        tx.delete();
        for (int k = 0; k < 6; k++) tx.push_back(8'h71 + 8'(k));
        send_msg(6, 1'b0, -1, 0, 1'b0);
        do_reset();
        load_abcd(3);
        p0 = pulses;
        send_msg(3, 1'b1, -1, 0, 1'b0);
        @(negedge clk_in);
        check("rst_abc_pulses", pulses - p0, 1);
        check("rst_abc_word", last_w, 32'h61626300);
        check("rst_abc_lwb", last_b, 2'b10);
        finish_msg();

        repeat (3) @(negedge clk_in);
        check("exp_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
